axi4_plic_arb: RTL and testbench
================================

Name: axi4_plic_arb

Overview:
- Two-master to one-slave AXI4 arbiter in front of the axi4_plic_top register port.
- Lets two bus masters (e.g. CPU hart and debug module) share the single PLIC AXI4 slave interface.
- One transaction (read or write burst) in flight at a time; round-robin between masters.
- Holds the grant for the whole burst, until RLAST or B handshake.

Parameters:
- AW, 32, address width of all AR/AW channels
- DW, 32, data width of R/W channels (strobe width DW/8)

Ports:
- PCLK  in  1  clock; all logic rising-edge
- PRESET  in  1  synchronous, active-high reset
- mN_araddr/arsize/arlen/arburst/arvalid  in  AW/3/8/2/1  master N read address, N=0,1
- mN_arready  out  1  master N read address ready
- mN_rdata/rresp/rlast/rvalid  out  DW/2/1/1  master N read data
- mN_rready  in  1  master N read data ready
- mN_awaddr/awsize/awlen/awburst/awvalid  in  AW/3/8/2/1  master N write address
- mN_awready  out  1  master N write address ready
- mN_wdata/wstrb/wlast/wvalid  in  DW/DW/8/1/1  master N write data
- mN_wready  out  1  master N write data ready
- mN_bresp/bvalid  out  2/1  master N write response
- mN_bready  in  1  master N write response ready
- s_* (same set, directions mirrored)  —  slave side, wired to axi4_plic_top
- grant  out  1  index of owning master (debug)
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (PRESET=1 at a PCLK edge):
  - state=IDLE, rr_ptr=0 (master 0 favoured first), grant=0, busy=0.
  - All mN_*ready, mN_rvalid, mN_bvalid, s_*valid, s_rready, s_bready = 0.
  - Reset mid-burst abandons the transaction; the slave is reset on the same PRESET.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE:
  - reqN = mN_arvalid | mN_awvalid.
  - If both masters request, pick master rr_ptr; otherwise pick the requester.
  - Within the chosen master, write (awvalid) beats read.
  - Registered grant; next cycle is RD_ADDR or WR_ADDR, so slave sees avalid 1 cycle after the master's request.
- RD_ADDR:
  - s_ar* = m[grant]_ar*; m[grant]_arready = s_arready.
  - On s_arvalid & s_arready -> RD_DATA.
- RD_DATA:
  - m[grant]_r* = s_r*; s_rready = m[grant]_rready.
  - On rvalid & rready & rlast -> IDLE; rr_ptr = ~grant.
- WR_ADDR:
  - AW channel forwarded like AR; W channel held (wready=0 even if wvalid is already high).
  - On AW handshake -> WR_DATA.
- WR_DATA:
  - W channel forwarded.
  - On wvalid & wready & wlast -> WR_RESP.
  - Beat count is not checked against awlen; wlast alone ends the phase.
- WR_RESP:
  - B channel forwarded.
  - On bvalid & bready -> IDLE; rr_ptr = ~grant.
- Non-granted master, and all channels not in the active phase:
  - ready/valid outputs forced 0; data/resp outputs driven 0.
- Forwarding is combinational (mux on registered grant/state); no added latency per beat. Back-to-back transactions have 1 IDLE bubble.
- A master dropping avalid before handshake is a protocol violation; the arbiter stays in *_ADDR.
- Response codes (rresp/bresp) pass through unchanged; the arbiter never generates errors.

Optional Feature:
- Macro: AXI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, master 0 always wins simultaneous requests; rr_ptr is not implemented.
- Undefined: round-robin as described above.

Test Plan:
- Single write: m0 aw 0x10000004, len 0, size 2, burst INCR; w 0x00f1001f, strb 0xF, wlast=1. Required response:
  - s_awvalid 1 cycle after m0_awvalid.
  - m0_bvalid with bresp=0; m1 sees no ready/valid.
  - busy falls the cycle after the B handshake.
- Read burst: m1 ar 0x10000004, arlen 1; rready held 1. Required response:
  - Two beats reach m1, rlast on beat 2; m1 readback of 0x10000004 = 0x00f1001f after the write above.
  - State returns to IDLE; rr_ptr=0.
- Contention: m0 and m1 both assert arvalid in the same cycle after reset. Required response:
  - m0 served first, then m1.
  - Repeat immediately: m1 wins the second round (alternation).
  - With AXI_ARB_FIXED_PRIO_EN: m0 wins both rounds.
- Early W: m0 wvalid asserted 3 cycles before awvalid. Required response:
  - m0_wready=0 until the AW handshake.
  - Data beat accepted only in WR_DATA.
- Back-pressure: s_arready low 5 cycles, m0_rready low on beat 1 for 4 cycles. Required response:
  - Grant held; no beat lost or duplicated; m1 request waits.
- Reset mid-burst: PRESET=1 during RD_DATA of an arlen=3 read. Required response:
  - Next cycle: busy=0, all valid/ready=0, grant=0.
  - New m1 read after reset completes normally.

Source files
------------

// File: rtl/axi4_plic_arb.sv
// Two-master to one-slave AXI4 arbiter in front of the PLIC register port: one burst in flight, grant held to RLAST / B.
// Build option: define AXI_ARB_FIXED_PRIO_EN for fixed priority (master 0 wins ties) instead of round-robin.
module axi4_plic_arb #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            PCLK,
    input  logic            PRESET,
    // master 0
    input  logic [AW-1:0]   m0_araddr,
    input  logic [2:0]      m0_arsize,
    input  logic [7:0]      m0_arlen,
    input  logic [1:0]      m0_arburst,
    input  logic            m0_arvalid,
    output logic            m0_arready,
    output logic [DW-1:0]   m0_rdata,
    output logic [1:0]      m0_rresp,
    output logic            m0_rlast,
    output logic            m0_rvalid,
    input  logic            m0_rready,
    input  logic [AW-1:0]   m0_awaddr,
    input  logic [2:0]      m0_awsize,
    input  logic [7:0]      m0_awlen,
    input  logic [1:0]      m0_awburst,
    input  logic            m0_awvalid,
    output logic            m0_awready,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    input  logic            m0_wlast,
    input  logic            m0_wvalid,
    output logic            m0_wready,
    output logic [1:0]      m0_bresp,
    output logic            m0_bvalid,
    input  logic            m0_bready,
    // master 1
    input  logic [AW-1:0]   m1_araddr,
    input  logic [2:0]      m1_arsize,
    input  logic [7:0]      m1_arlen,
    input  logic [1:0]      m1_arburst,
    input  logic            m1_arvalid,
    output logic            m1_arready,
    output logic [DW-1:0]   m1_rdata,
    output logic [1:0]      m1_rresp,
    output logic            m1_rlast,
    output logic            m1_rvalid,
    input  logic            m1_rready,
    input  logic [AW-1:0]   m1_awaddr,
    input  logic [2:0]      m1_awsize,
    input  logic [7:0]      m1_awlen,
    input  logic [1:0]      m1_awburst,
    input  logic            m1_awvalid,
    output logic            m1_awready,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    input  logic            m1_wlast,
    input  logic            m1_wvalid,
    output logic            m1_wready,
    output logic [1:0]      m1_bresp,
    output logic            m1_bvalid,
    input  logic            m1_bready,
    // slave
    output logic [AW-1:0]   s_araddr,
    output logic [2:0]      s_arsize,
    output logic [7:0]      s_arlen,
    output logic [1:0]      s_arburst,
    output logic            s_arvalid,
    input  logic            s_arready,
    input  logic [DW-1:0]   s_rdata,
    input  logic [1:0]      s_rresp,
    input  logic            s_rlast,
    input  logic            s_rvalid,
    output logic            s_rready,
    output logic [AW-1:0]   s_awaddr,
    output logic [2:0]      s_awsize,
    output logic [7:0]      s_awlen,
    output logic [1:0]      s_awburst,
    output logic            s_awvalid,
    input  logic            s_awready,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    output logic            s_wlast,
    output logic            s_wvalid,
    input  logic            s_wready,
    input  logic [1:0]      s_bresp,
    input  logic            s_bvalid,
    output logic            s_bready,
    output logic            grant,
    output logic            busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    state_t state_r;
    logic   grant_r;
    logic   busy_r;
`ifndef AXI_ARB_FIXED_PRIO_EN
    logic   rr_ptr_r;
`endif
    logic   req0_s;
    logic   req1_s;
    logic   pick_s;
    logic   pick_wr_s;

    // Arbitration: choose the master to serve and whether its write or read goes first
    always_comb begin
        req0_s = m0_arvalid | m0_awvalid;
        req1_s = m1_arvalid | m1_awvalid;
        if (req0_s && req1_s) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
            pick_s = 1'b0;
`else
            pick_s = rr_ptr_r;
`endif
        end else if (req1_s) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
        if (pick_s) begin
            pick_wr_s = m1_awvalid;
        end else begin
            pick_wr_s = m0_awvalid;
        end
    end

    // Transaction FSM with registered grant/busy; the owner is released on RLAST or the B handshake
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r  <= IDLE;
            grant_r  <= 1'b0;
            busy_r   <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
            rr_ptr_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (req0_s || req1_s) begin
                        grant_r <= pick_s;
                        busy_r  <= 1'b1;
                        state_r <= pick_wr_s ? WR_ADDR : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (s_arvalid && s_arready) begin
                        state_r <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (s_rvalid && s_rready && s_rlast) begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
                        rr_ptr_r <= ~grant_r;
`endif
                    end
                end
                WR_ADDR: begin
                    if (s_awvalid && s_awready) begin
                        state_r <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (s_wvalid && s_wready && s_wlast) begin
                        state_r <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_bvalid && s_bready) begin
                        state_r  <= IDLE;
                        busy_r   <= 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
                        rr_ptr_r <= ~grant_r;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = grant_r;
    assign busy  = busy_r;

    // Channel forwarding: only the active phase of the granted master is connected, everything else is 0
    always_comb begin
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m0_rlast   = 1'b0;
        m0_rvalid  = 1'b0;
        m0_awready = 1'b0;
        m0_wready  = 1'b0;
        m0_bresp   = 2'b00;
        m0_bvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_rlast   = 1'b0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = 2'b00;
        m1_bvalid  = 1'b0;
        s_araddr   = '0;
        s_arsize   = 3'd0;
        s_arlen    = 8'd0;
        s_arburst  = 2'd0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awsize   = 3'd0;
        s_awlen    = 8'd0;
        s_awburst  = 2'd0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wlast    = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        case (state_r)
            RD_ADDR: begin
                if (grant_r) begin
                    s_araddr   = m1_araddr;
                    s_arsize   = m1_arsize;
                    s_arlen    = m1_arlen;
                    s_arburst  = m1_arburst;
                    s_arvalid  = m1_arvalid;
                    m1_arready = s_arready;
                end else begin
                    s_araddr   = m0_araddr;
                    s_arsize   = m0_arsize;
                    s_arlen    = m0_arlen;
                    s_arburst  = m0_arburst;
                    s_arvalid  = m0_arvalid;
                    m0_arready = s_arready;
                end
            end
            RD_DATA: begin
                if (grant_r) begin
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                    m1_rvalid = s_rvalid;
                    s_rready  = m1_rready;
                end else begin
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                    m0_rvalid = s_rvalid;
                    s_rready  = m0_rready;
                end
            end
            WR_ADDR: begin
                if (grant_r) begin
                    s_awaddr   = m1_awaddr;
                    s_awsize   = m1_awsize;
                    s_awlen    = m1_awlen;
                    s_awburst  = m1_awburst;
                    s_awvalid  = m1_awvalid;
                    m1_awready = s_awready;
                end else begin
                    s_awaddr   = m0_awaddr;
                    s_awsize   = m0_awsize;
                    s_awlen    = m0_awlen;
                    s_awburst  = m0_awburst;
                    s_awvalid  = m0_awvalid;
                    m0_awready = s_awready;
                end
            end
            WR_DATA: begin
                if (grant_r) begin
                    s_wdata   = m1_wdata;
                    s_wstrb   = m1_wstrb;
                    s_wlast   = m1_wlast;
                    s_wvalid  = m1_wvalid;
                    m1_wready = s_wready;
                end else begin
                    s_wdata   = m0_wdata;
                    s_wstrb   = m0_wstrb;
                    s_wlast   = m0_wlast;
                    s_wvalid  = m0_wvalid;
                    m0_wready = s_wready;
                end
            end
            WR_RESP: begin
                if (grant_r) begin
                    m1_bresp  = s_bresp;
                    m1_bvalid = s_bvalid;
                    s_bready  = m1_bready;
                end else begin
                    m0_bresp  = s_bresp;
                    m0_bvalid = s_bvalid;
                    s_bready  = m0_bready;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_axi4_plic_arb.sv
// Bench for axi4_plic_arb: two scripted masters, a behavioural PLIC slave and a scoreboard of expected beats/order.
module tb_axi4_plic_arb;

    logic        clk;
    logic        preset;
    logic [31:0] m_araddr  [2];
    logic [2:0]  m_arsize  [2];
    logic [7:0]  m_arlen   [2];
    logic [1:0]  m_arburst [2];
    logic        m_arvalid [2];
    logic        m_arready [2];
    logic [31:0] m_rdata   [2];
    logic [1:0]  m_rresp   [2];
    logic        m_rlast   [2];
    logic        m_rvalid  [2];
    logic        m_rready  [2];
    logic [31:0] m_awaddr  [2];
    logic [2:0]  m_awsize  [2];
    logic [7:0]  m_awlen   [2];
    logic [1:0]  m_awburst [2];
    logic        m_awvalid [2];
    logic        m_awready [2];
    logic [31:0] m_wdata   [2];
    logic [3:0]  m_wstrb   [2];
    logic        m_wlast   [2];
    logic        m_wvalid  [2];
    logic        m_wready  [2];
    logic [1:0]  m_bresp   [2];
    logic        m_bvalid  [2];
    logic        m_bready  [2];
    logic [31:0] s_araddr, s_awaddr, s_rdata, s_wdata;
    logic [2:0]  s_arsize, s_awsize;
    logic [7:0]  s_arlen, s_awlen;
    logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;
    logic [3:0]  s_wstrb;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
    logic        s_bvalid, s_bready;
    logic        grant, busy;

    int checks;
    int errors;
    int ar_hold;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] mem     [logic [31:0]];
    logic [32:0] exp_r0[$];
    logic [32:0] exp_r1[$];
    logic [1:0]  exp_b0[$];
    logic [1:0]  exp_b1[$];
    int          exp_order[$];

    axi4_plic_arb #(.AW(32), .DW(32)) dut (
        .PCLK(clk), .PRESET(preset),
        .m0_araddr(m_araddr[0]), .m0_arsize(m_arsize[0]), .m0_arlen(m_arlen[0]), .m0_arburst(m_arburst[0]),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]), .m0_rvalid(m_rvalid[0]),
        .m0_rready(m_rready[0]),
        .m0_awaddr(m_awaddr[0]), .m0_awsize(m_awsize[0]), .m0_awlen(m_awlen[0]), .m0_awburst(m_awburst[0]),
        .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wlast(m_wlast[0]), .m0_wvalid(m_wvalid[0]),
        .m0_wready(m_wready[0]), .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
        .m1_araddr(m_araddr[1]), .m1_arsize(m_arsize[1]), .m1_arlen(m_arlen[1]), .m1_arburst(m_arburst[1]),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]), .m1_rvalid(m_rvalid[1]),
        .m1_rready(m_rready[1]),
        .m1_awaddr(m_awaddr[1]), .m1_awsize(m_awsize[1]), .m1_awlen(m_awlen[1]), .m1_awburst(m_awburst[1]),
        .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wlast(m_wlast[1]), .m1_wvalid(m_wvalid[1]),
        .m1_wready(m_wready[1]), .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
        .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arlen(s_arlen), .s_arburst(s_arburst),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awlen(s_awlen), .s_awburst(s_awburst),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dflt_word(input logic [31:0] a);
        return {16'hA5A5, a[15:0]};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt_word(a);
    endfunction

    function automatic logic [4:0] vr_m(input int k);
        return {m_arready[k], m_rvalid[k], m_awready[k], m_wready[k], m_bvalid[k]};
    endfunction

    function automatic logic [4:0] vr_s();
        return {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
    endfunction

    // Behavioural PLIC slave: one read and one write in progress at most, plain word memory
    initial begin : slave_model
        bit          rst_q, arh, rh, awh, wh, bh, arv, a_wlast;
        bit          rd_busy;
        int          w_state, rbeat, rlen;
        logic [31:0] raddr, waddr, a_araddr, a_awaddr, a_wdata, word;
        logic [7:0]  a_arlen;
        logic [3:0]  a_wstrb;
        rd_busy = 1'b0; w_state = 0; rbeat = 0; rlen = 0; raddr = 32'd0; waddr = 32'd0;
        s_arready = 1'b0; s_rdata = 32'd0; s_rresp = 2'b00; s_rlast = 1'b0; s_rvalid = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bresp = 2'b00; s_bvalid = 1'b0;
        forever begin
            @(negedge clk);
            rst_q = preset;
            arh = s_arvalid && s_arready; rh = s_rvalid && s_rready; arv = s_arvalid;
            awh = s_awvalid && s_awready; wh = s_wvalid && s_wready; bh = s_bvalid && s_bready;
            a_araddr = s_araddr; a_arlen = s_arlen; a_awaddr = s_awaddr;
            a_wdata = s_wdata; a_wstrb = s_wstrb; a_wlast = s_wlast;
            @(posedge clk);
            #1;
            if (rst_q) begin
                rd_busy = 1'b0;
                w_state = 0;
            end else begin
                if (arv && ar_hold > 0) ar_hold--;
                if (arh) begin
                    rd_busy = 1'b1; raddr = a_araddr; rlen = int'(a_arlen); rbeat = 0;
                end else if (rh) begin
                    if (rbeat == rlen) rd_busy = 1'b0;
                    else begin rbeat++; raddr = raddr + 32'd4; end
                end
                if (awh) begin w_state = 1; waddr = a_awaddr; end
                if (wh) begin
                    word = mem.exists(waddr) ? mem[waddr] : dflt_word(waddr);
                    for (int i = 0; i < 4; i++) if (a_wstrb[i]) word[8*i +: 8] = a_wdata[8*i +: 8];
                    mem[waddr] = word;
                    waddr = waddr + 32'd4;
                    if (a_wlast) w_state = 2;
                end
                if (bh) w_state = 0;
            end
            s_arready = !rd_busy && (ar_hold == 0);
            s_rvalid  = rd_busy;
            s_rdata   = rd_busy ? (mem.exists(raddr) ? mem[raddr] : dflt_word(raddr)) : 32'd0;
            s_rlast   = rd_busy && (rbeat == rlen);
            s_awready = (w_state == 0);
            s_wready  = (w_state != 2);
            s_bvalid  = (w_state == 2);
        end
    end

    // Scoreboard monitor: grant order, beat data, responses and master isolation
    initial begin : monitor
        logic [32:0] e_r;
        logic [1:0]  e_b;
        bit          have;
        int          e_o;
        forever begin
            @(negedge clk);
            if (!preset) begin
                checks++;
                if ((|vr_m(0)) && (|vr_m(1))) begin
                    errors++;
                    $display("FAIL isolation: m0 rdy/vld=%b m1 rdy/vld=%b, required one side all zero", vr_m(0), vr_m(1));
                end
                for (int k = 0; k < 2; k++) begin
                    if ((m_arvalid[k] && m_arready[k]) || (m_awvalid[k] && m_awready[k])) begin
                        checks++;
                        if (exp_order.size() == 0) begin
                            errors++;
                            $display("FAIL order: m%0d got address handshake, none expected", k);
                        end else begin
                            e_o = exp_order.pop_front();
                            if (e_o != k) begin
                                errors++;
                                $display("FAIL order: m%0d served, required m%0d", k, e_o);
                            end
                        end
                    end
                    if (m_rvalid[k] && m_rready[k]) begin
                        checks++;
                        have = 1'b0;
                        e_r = 33'd0;
                        if (k == 0 && exp_r0.size() > 0) begin e_r = exp_r0.pop_front(); have = 1'b1; end
                        else if (k == 1 && exp_r1.size() > 0) begin e_r = exp_r1.pop_front(); have = 1'b1; end
                        if (!have) begin
                            errors++;
                            $display("FAIL rbeat m%0d: unexpected beat data=%h", k, m_rdata[k]);
                        end else if ({m_rlast[k], m_rdata[k]} !== e_r || m_rresp[k] !== 2'b00) begin
                            errors++;
                            $display("FAIL rbeat m%0d: got last=%b data=%h resp=%b, required last=%b data=%h resp=00",
                                     k, m_rlast[k], m_rdata[k], m_rresp[k], e_r[32], e_r[31:0]);
                        end
                    end
                    if (m_bvalid[k] && m_bready[k]) begin
                        checks++;
                        have = 1'b0;
                        e_b = 2'b00;
                        if (k == 0 && exp_b0.size() > 0) begin e_b = exp_b0.pop_front(); have = 1'b1; end
                        else if (k == 1 && exp_b1.size() > 0) begin e_b = exp_b1.pop_front(); have = 1'b1; end
                        if (!have) begin
                            errors++;
                            $display("FAIL bresp m%0d: unexpected response %b", k, m_bresp[k]);
                        end else if (m_bresp[k] !== e_b) begin
                            errors++;
                            $display("FAIL bresp m%0d: got %b, required %b", k, m_bresp[k], e_b);
                        end
                    end
                end
            end
        end
    end

    task automatic m_read(input int m, input logic [31:0] addr, input int len, input int rhold);
        int hold, n;
        bit arh, rh, lst, stall, done;
        hold = rhold;
        for (int i = 0; i <= len; i++) begin
            if (m == 0) exp_r0.push_back({(i == len), exp_word(addr + 32'(4 * i))});
            else        exp_r1.push_back({(i == len), exp_word(addr + 32'(4 * i))});
        end
        m_araddr[m] = addr; m_arlen[m] = 8'(len); m_arsize[m] = 3'd2; m_arburst[m] = 2'd1;
        m_arvalid[m] = 1'b1; m_rready[m] = (hold == 0);
        n = 0; done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            arh = m_arvalid[m] && m_arready[m];
            rh = m_rvalid[m] && m_rready[m];
            lst = m_rlast[m];
            stall = m_rvalid[m] && !m_rready[m];
            @(posedge clk);
            #1;
            if (arh) m_arvalid[m] = 1'b0;
            if (rh && lst) done = 1'b1;
            if (stall && hold > 0) hold--;
            m_rready[m] = (hold == 0);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL read_timeout m%0d: done=%0d after %0d cycles, required 1", m, done, n);
        end
        checks++;
        if ((m == 0 ? exp_r0.size() : exp_r1.size()) != 0) begin
            errors++;
            $display("FAIL read_beats m%0d: %0d beats outstanding, required 0", m, (m == 0 ? exp_r0.size() : exp_r1.size()));
        end
    endtask

    task automatic m_write(input int m, input logic [31:0] addr, input logic [31:0] data, input int early, input bit tchk);
        int n;
        bit awh, wh, bh, aw_done, b_done;
        ref_mem[addr] = data;
        if (m == 0) exp_b0.push_back(2'b00); else exp_b1.push_back(2'b00);
        m_wdata[m] = data; m_wstrb[m] = 4'hF; m_wlast[m] = 1'b1; m_bready[m] = 1'b1;
        if (early > 0) begin
            m_wvalid[m] = 1'b1;
            repeat (early) begin
                @(negedge clk);
                checks++;
                if (m_wready[m] !== 1'b0 || s_wvalid !== 1'b0) begin
                    errors++;
                    $display("FAIL early_w m%0d: wready=%b s_wvalid=%b before AW, required 0/0", m, m_wready[m], s_wvalid);
                end
                @(posedge clk);
                #1;
            end
        end
        m_awaddr[m] = addr; m_awlen[m] = 8'd0; m_awsize[m] = 3'd2; m_awburst[m] = 2'd1;
        m_awvalid[m] = 1'b1; m_wvalid[m] = 1'b1;
        n = 0; aw_done = 1'b0; b_done = 1'b0;
        while (!b_done && n < 300) begin
            @(negedge clk);
            awh = m_awvalid[m] && m_awready[m];
            wh = m_wvalid[m] && m_wready[m];
            bh = m_bvalid[m] && m_bready[m];
            if (!aw_done) begin
                checks++;
                if (m_wready[m] !== 1'b0) begin
                    errors++;
                    $display("FAIL wready_before_aw m%0d: got %b, required 0", m, m_wready[m]);
                end
            end
            if (tchk && n < 2) begin
                checks++;
                if (s_awvalid !== (n == 1)) begin
                    errors++;
                    $display("FAIL aw_latency: cycle %0d s_awvalid=%b, required %b", n, s_awvalid, (n == 1));
                end
            end
            if (tchk) begin
                checks++;
                if (vr_m(1 - m) !== 5'b00000) begin
                    errors++;
                    $display("FAIL idle_master: m%0d rdy/vld=%b, required 00000", 1 - m, vr_m(1 - m));
                end
            end
            if (tchk && bh) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_at_b: got %b, required 1", busy);
                end
            end
            @(posedge clk);
            #1;
            if (awh) begin aw_done = 1'b1; m_awvalid[m] = 1'b0; end
            if (wh) m_wvalid[m] = 1'b0;
            if (bh) b_done = 1'b1;
            n++;
        end
        checks++;
        if (!b_done) begin
            errors++;
            $display("FAIL write_timeout m%0d: b_done=%0d after %0d cycles, required 1", m, b_done, n);
        end
        if (tchk) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_after_b: got %b, required 0", busy);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        preset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        preset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b grant=%b, required 0/0", busy, grant);
        end
        checks++;
        if ({vr_m(0), vr_m(1), vr_s()} !== 15'd0) begin
            errors++;
            $display("FAIL reset_handshake: m0=%b m1=%b s=%b, required all 0", vr_m(0), vr_m(1), vr_s());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        exp_order.push_back(0);
        m_write(0, 32'h1000_0004, 32'h00f1_001f, 0, 1'b1);
    endtask

    task automatic test_read_burst();
        exp_order.push_back(1);
        m_read(1, 32'h1000_0004, 1, 0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: busy=%b after burst, required 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        preset = 1'b1;
        @(posedge clk);
        #1;
        preset = 1'b0;
`ifdef AXI_ARB_FIXED_PRIO_EN
        exp_order.push_back(0); exp_order.push_back(0); exp_order.push_back(1);
`else
        exp_order.push_back(0); exp_order.push_back(1); exp_order.push_back(0);
`endif
        fork
            begin
                m_read(0, 32'h1000_0020, 0, 0);
                m_read(0, 32'h1000_0024, 0, 0);
            end
            m_read(1, 32'h1000_0028, 0, 0);
        join
        checks++;
        if (exp_order.size() != 0) begin
            errors++;
            $display("FAIL contention_order: %0d grants outstanding, required 0", exp_order.size());
        end
    endtask

    task automatic test_early_w();
        exp_order.push_back(0);
        m_write(0, 32'h1000_0010, 32'h1234_5678, 3, 1'b0);
    endtask

    task automatic test_back_pressure();
        ar_hold = 5;
        @(posedge clk);
        #1;
        exp_order.push_back(0);
        exp_order.push_back(1);
        fork
            m_read(0, 32'h1000_0010, 1, 4);
            begin
                repeat (2) @(posedge clk);
                #1;
                m_read(1, 32'h1000_0030, 0, 0);
            end
        join
    endtask

    task automatic test_reset_mid_burst();
        int n, beats;
        bit arh, rh;
        exp_order.push_back(1);
        for (int i = 0; i < 4; i++) exp_r1.push_back({(i == 3), exp_word(32'h1000_0040 + 32'(4 * i))});
        m_araddr[1] = 32'h1000_0040; m_arlen[1] = 8'd3; m_arvalid[1] = 1'b1; m_rready[1] = 1'b1;
        n = 0; beats = 0;
        while (beats < 1 && n < 100) begin
            @(negedge clk);
            arh = m_arvalid[1] && m_arready[1];
            rh = m_rvalid[1] && m_rready[1];
            @(posedge clk);
            #1;
            if (arh) m_arvalid[1] = 1'b0;
            if (rh) beats++;
            n++;
        end
        checks++;
        if (beats < 1) begin
            errors++;
            $display("FAIL mid_burst_start: beats=%0d, required 1", beats);
        end
        preset = 1'b1;
        @(posedge clk);
        #1;
        preset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || grant !== 1'b0) begin
            errors++;
            $display("FAIL mid_burst_reset: busy=%b grant=%b, required 0/0", busy, grant);
        end
        checks++;
        if ({vr_m(0), vr_m(1), vr_s()} !== 15'd0) begin
            errors++;
            $display("FAIL mid_burst_handshake: m0=%b m1=%b s=%b, required all 0", vr_m(0), vr_m(1), vr_s());
        end
        exp_r1.delete();
        @(posedge clk);
        #1;
        exp_order.push_back(1);
        m_read(1, 32'h1000_0010, 1, 0);
    endtask

    initial begin
        checks = 0; errors = 0; ar_hold = 0;
        preset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_araddr[k] = 32'd0; m_arsize[k] = 3'd2; m_arlen[k] = 8'd0; m_arburst[k] = 2'd1; m_arvalid[k] = 1'b0;
            m_rready[k] = 1'b0;
            m_awaddr[k] = 32'd0; m_awsize[k] = 3'd2; m_awlen[k] = 8'd0; m_awburst[k] = 2'd1; m_awvalid[k] = 1'b0;
            m_wdata[k] = 32'd0; m_wstrb[k] = 4'h0; m_wlast[k] = 1'b0; m_wvalid[k] = 1'b0; m_bready[k] = 1'b0;
        end
        test_reset();
        test_single_write();
        test_read_burst();
        test_contention();
        test_early_w();
        test_back_pressure();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1);
    end

endmodule
